// File: rtl/mra_controller.sv
// Work-list fetch stage: issues one credited memory read per entry, buffers the
// in-order responses and streams them to the WIP-side consumer.
module mra_controller #(
  parameter int ADDR_WIDTH  = 64,
  parameter int WL_LEN_BITS = 8,
  parameter int DATA_WIDTH  = 64,
  parameter int ENTRY_BYTES = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_dispatch_i,
  input  logic [ADDR_WIDTH-1:0]  WL_addr_i,
  input  logic [WL_LEN_BITS-1:0] WL_len_i,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr_o,
  input  logic                   mem_resp_valid_i,
  input  logic [DATA_WIDTH-1:0]  mem_resp_data_i,
  output logic                   wl_entry_valid_o,
  output logic [DATA_WIDTH-1:0]  wl_entry_data_o,
  input  logic                   wl_entry_ready_i,
  output logic                   busy_o,
  output logic                   fetch_done_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_WIDTH-1:0]  STRIDE       = ADDR_WIDTH'(ENTRY_BYTES);
  localparam logic [CW-1:0]          FULL_CREDITS = CW'(FIFO_DEPTH);
  localparam logic [WL_LEN_BITS-1:0] LEN_ONE      = WL_LEN_BITS'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  baseAddr_q, baseAddr_d;
  logic [WL_LEN_BITS-1:0] reqIdx_q, reqIdx_d;
  logic [WL_LEN_BITS-1:0] remaining_q, remaining_d;
  logic [WL_LEN_BITS-1:0] toDeliver_q, toDeliver_d;
  logic [CW-1:0]          credits_q, credits_d;
  logic [CW-1:0]          count_q, count_d;
  logic [PW-1:0]          wrPtr_q, wrPtr_d;
  logic [PW-1:0]          rdPtr_q, rdPtr_d;
  logic [DATA_WIDTH-1:0]  fifoMem_q [FIFO_DEPTH];
  logic                   reqValid_q, reqValid_d;
  logic [ADDR_WIDTH-1:0]  reqAddr_q, reqAddr_d;
  logic                   entryValid_q, entryValid_d;
  logic [DATA_WIDTH-1:0]  entryData_q, entryData_d;
  logic                   busy_q, busy_d;
  logic                   fetchDone_q, fetchDone_d;
  logic                   reqFire, popFire, pushEn;

  always_comb begin
    reqFire = reqValid_q & mem_req_ready_i;
    popFire = entryValid_q & wl_entry_ready_i;
    pushEn  = mem_resp_valid_i & (state_q != IDLE);

    state_d     = state_q;
    baseAddr_d  = baseAddr_q;
    reqIdx_d    = reqIdx_q;
    remaining_d = remaining_q;
    toDeliver_d = toDeliver_q;
    fetchDone_d = 1'b0;

    credits_d = credits_q - CW'(reqFire) + CW'(popFire);
    count_d   = count_q + CW'(pushEn) - CW'(popFire);
    wrPtr_d   = wrPtr_q + PW'(pushEn);
    rdPtr_d   = rdPtr_q + PW'(popFire);
    if (popFire) toDeliver_d = toDeliver_q - LEN_ONE;

    unique case (state_q)
      IDLE: begin
        if (start_dispatch_i) begin
          if (WL_len_i != '0) begin
            baseAddr_d  = WL_addr_i;
            reqIdx_d    = '0;
            remaining_d = WL_len_i;
            toDeliver_d = WL_len_i;
            state_d     = ISSUE;
          end else begin
            fetchDone_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (reqFire) begin
          reqIdx_d    = reqIdx_q + LEN_ONE;
          remaining_d = remaining_q - LEN_ONE;
          if (remaining_q == LEN_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (toDeliver_d == '0) begin
          fetchDone_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of the next-cycle view, so the head slot
    // picks up a same-cycle write only once it has landed in the FIFO.
    reqValid_d   = (state_d == ISSUE) && (credits_d != '0);
    reqAddr_d    = baseAddr_d + ADDR_WIDTH'(reqIdx_d) * STRIDE;
    busy_d       = (state_d != IDLE);
    entryValid_d = (count_d != '0);
    entryData_d  = entryData_q;
    if (count_d != '0) begin
      if (pushEn && (wrPtr_q == rdPtr_d)) entryData_d = mem_resp_data_i;
      else                                entryData_d = fifoMem_q[rdPtr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      baseAddr_q   <= '0;
      reqIdx_q     <= '0;
      remaining_q  <= '0;
      toDeliver_q  <= '0;
      credits_q    <= FULL_CREDITS;
      count_q      <= '0;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      reqValid_q   <= 1'b0;
      reqAddr_q    <= '0;
      entryValid_q <= 1'b0;
      entryData_q  <= '0;
      busy_q       <= 1'b0;
      fetchDone_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      baseAddr_q   <= baseAddr_d;
      reqIdx_q     <= reqIdx_d;
      remaining_q  <= remaining_d;
      toDeliver_q  <= toDeliver_d;
      credits_q    <= credits_d;
      count_q      <= count_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      reqValid_q   <= reqValid_d;
      reqAddr_q    <= reqAddr_d;
      entryValid_q <= entryValid_d;
      entryData_q  <= entryData_d;
      busy_q       <= busy_d;
      fetchDone_q  <= fetchDone_d;
    end
  end

  // Credits bound occupancy, so the storage needs no full check or reset.
  always_ff @(posedge clk_i) begin
    if (pushEn) fifoMem_q[wrPtr_q] <= mem_resp_data_i;
  end

  assign mem_req_valid_o  = reqValid_q;
  assign mem_req_addr_o   = reqAddr_q;
  assign wl_entry_valid_o = entryValid_q;
  assign wl_entry_data_o  = entryData_q;
  assign busy_o           = busy_q;
  assign fetch_done_o     = fetchDone_q;

endmodule

// File: doc/mra_controller.md
# mra_controller

The MRA controller is the work-list fetch stage directly downstream of the SN controller. On `start_dispatch` it captures the work-list base address and length (`WL_addr`, `WL_len`). It then issues one memory read per work-list entry, with a bounded number of reads in flight, and buffers the in-order responses in a FIFO. Entries are streamed to the WIP-side consumer over a valid/ready handshake, and `fetch_done` is pulsed once every entry has been handed off.

## Interface
- `ADDR_WIDTH`, 64, byte-address width of `WL_addr` and `mem_req_addr`.
- `WL_LEN_BITS`, 8, width of `WL_len`; the work list holds 0..2^WL_LEN_BITS-1 entries.
- `DATA_WIDTH`, 64, width of one work-list entry.
- `ENTRY_BYTES`, 8, address stride between entries.
- `FIFO_DEPTH`, 4, entry FIFO depth; also the credit limit for in-flight reads. Power of two, ≥2.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_dispatch`  in  1  one-cycle pulse that starts a fetch.
- `WL_addr`  in  ADDR_WIDTH  work-list base address; sampled only with `start_dispatch`.
- `WL_len`  in  WL_LEN_BITS  entry count; sampled only with `start_dispatch`.
- `mem_req_valid`  out  1  read request valid.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_req_addr`  out  ADDR_WIDTH  read address.
- `mem_resp_valid`  in  1  read data valid. Responses return in order and are never back-pressured.
- `mem_resp_data`  in  DATA_WIDTH  read data.
- `wl_entry_valid`  out  1  FIFO head is valid.
- `wl_entry_data`  out  DATA_WIDTH  FIFO head data.
- `wl_entry_ready`  in  1  consumer takes the head.
- `busy`  out  1  a fetch is in progress.
- `fetch_done`  out  1  one-cycle pulse when all entries have been delivered.

## Operation
- **States:** IDLE, ISSUE, DRAIN.
- **IDLE:**
  - `start_dispatch` with `WL_len` ≠ 0: latch `base` ← `WL_addr`, `remaining` ← `WL_len`, `to_deliver` ← `WL_len`, then go to ISSUE.
  - `start_dispatch` with `WL_len` = 0: stay in IDLE and pulse `fetch_done` in the next cycle. No request is issued.
- **ISSUE:**
  - `mem_req_valid` = (`credits` > 0).
  - `mem_req_addr` = `base` + `idx`×`ENTRY_BYTES`, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH).
  - On each request handshake (`valid` & `ready`): `idx`++, `remaining`--.
  - When the final request handshakes, go to DRAIN.
  - `mem_req_addr` is stable while `valid` is high and `ready` is low.
- **DRAIN:** no requests are issued. When `to_deliver` reaches 0, pulse `fetch_done` and return to IDLE.
- **Credits:**
  - `credits` = FIFO_DEPTH − (outstanding reads + FIFO occupancy).
  - A request handshake decrements it; a consumer pop (`wl_entry_valid` & `wl_entry_ready`) increments it.
  - A request and a pop in the same cycle leave it unchanged.
  - A response moves a credit from outstanding to occupancy, so the FIFO can never overflow.
- **Responses:**
  - In ISSUE or DRAIN, each `mem_resp_valid` writes `mem_resp_data` into the FIFO.
  - In IDLE, responses are dropped. This covers stray responses after a reset.
- **Delivery:** each pop decrements `to_deliver`.
- **Simultaneous events:** a FIFO write and pop in the same cycle keep occupancy unchanged. A write into an empty FIFO is not bypassed to the output.
- **Dispatch while busy:** `start_dispatch` in ISSUE or DRAIN is ignored and the latched values are unchanged.
- **Reset mid-operation:** all state, counters, credits and the FIFO are cleared and the block returns to IDLE. Nothing is retried.

## Timing
- **Reset values:** `mem_req_valid`=0, `mem_req_addr`=0, `wl_entry_valid`=0, `wl_entry_data`=0, `busy`=0, `fetch_done`=0.
- **Start of fetch:** with `start_dispatch` at cycle T, `busy` and `mem_req_valid` rise at T+1 with `mem_req_addr` = `WL_addr`.
- **Request throughput:** with `ready` held high and credits available, requests issue back-to-back, one per cycle.
- **Response-to-output latency:** a response at cycle R is presented on `wl_entry_valid`/`wl_entry_data` at R+1 at the earliest.
- **Completion:** `fetch_done` is asserted in the cycle after the last pop. `busy` falls in that same cycle. A new `start_dispatch` is accepted in that cycle.
- **Zero length:** `start_dispatch` at T gives `fetch_done` at T+1, and `busy` stays 0 throughout.
- **Output registers:** `wl_entry_data` holds while `valid` is high and `ready` is low. All outputs are driven from registers.

## Test plan
- **Basic fetch:** `WL_addr`=0x1000, `WL_len`=3, memory always ready with 2-cycle response latency, consumer always ready → requests at 0x1000, 0x1008, 0x1010 on consecutive cycles; three entries delivered in order; one `fetch_done` pulse; `busy` low afterwards.
- **Credit stall:** `WL_len`=8, `wl_entry_ready`=0 → exactly 4 requests issue, then `mem_req_valid` stays 0. Raising `ready` releases the remaining 4 requests; all 8 entries are delivered in order.
- **Address wrap and request back-pressure:** `WL_addr`=0xFFFF_FFFF_FFFF_FFF8, `WL_len`=2, `mem_req_ready` low for 3 cycles → the first address holds stable while stalled; the second address is 0x0.
- **Zero length and ignored restart:** `WL_len`=0 → `fetch_done` at T+1 with no requests. Then `start_dispatch` pulses mid-fetch of `WL_len`=5 → still exactly 5 requests and a single `fetch_done`.
- **Reset mid-fetch:** `rst` asserted after 2 of 6 requests → all outputs return to their reset values at the next edge. A stale response while in IDLE is not delivered. A new fetch with `WL_len`=2 then completes normally.
